// File: rtl/movo_pkg.sv
// Shared types, encodings and sizing helpers for the MOVO v2 frame scheduler.
package movo_pkg;

    localparam int FRAME_STEPS = 32;
    localparam int VAL_W       = 16;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int FRAME_STEP_W = cnt_w(FRAME_STEPS);

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_CTRL  = 2'd1,
        SRC_HOST  = 2'd2,
        SRC_FAULT = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [VAL_W-1:0] a;
        logic signed [VAL_W-1:0] b;
    } setpoint_t;

endpackage

// File: rtl/movo_step_timer.sv
// BIT_DIV prescaler plus step counter; slot_o marks the last clock of each step slot.
module movo_step_timer
    import movo_pkg::*;
#(
    parameter int BIT_DIV = 4,
    parameter int STEP_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    output logic              slot_o,
    output logic [STEP_W-1:0] step_o
);

    localparam int DIV_W = cnt_w(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0]  div_q,  div_d;
    logic [STEP_W-1:0] step_q, step_d;

    assign slot_o = (div_q == DIV_LAST);
    assign step_o = step_q;

    always_comb begin
        div_d  = div_q;
        step_d = step_q;
        if (clear_i) begin
            div_d  = '0;
            step_d = '0;
        end else if (slot_o) begin
            div_d  = '0;
            step_d = step_q + STEP_W'(1);
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            step_q <= '0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/movo_scheduler.sv
// Frame scheduler and setpoint arbiter for the MOVO v2 serializer: FSM, per-source
// pending registers, commit-time arbitration and the controller watchdog.
module movo_scheduler
    import movo_pkg::*;
#(
    parameter int BIT_DIV     = 4,
    parameter int GAP_STEPS   = 8,
    parameter int WDOG_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    fault,
    input  logic                    host_mode,
    input  logic                    ctrl_valid,
    output logic                    ctrl_ready,
    input  logic signed [VAL_W-1:0] ctrl_a,
    input  logic signed [VAL_W-1:0] ctrl_b,
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic signed [VAL_W-1:0] host_a,
    input  logic signed [VAL_W-1:0] host_b,
    output logic                    ser_en,
    output logic signed [VAL_W-1:0] value_a,
    output logic signed [VAL_W-1:0] value_b,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic [1:0]              src,
    output logic                    stale,
    output logic                    busy
);

    localparam int STEP_W = cnt_w((GAP_STEPS > FRAME_STEPS) ? GAP_STEPS : FRAME_STEPS);
    localparam int WD_W   = cnt_w(WDOG_FRAMES + 1);
    localparam logic [STEP_W-1:0] GAP_LAST   = STEP_W'(GAP_STEPS - 1);
    localparam logic [STEP_W-1:0] FRAME_LAST = STEP_W'(FRAME_STEPS - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(WDOG_FRAMES);
    localparam int IDX_CTRL = 0;
    localparam int IDX_HOST = 1;

    state_t            state_q, state_d;
    logic              timer_clear;
    logic              slot;
    logic [STEP_W-1:0] step;
    logic              commit;

    setpoint_t         val_q, val_d;
    src_t              src_q, src_d;
    logic              stale_q, stale_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              ser_en_q, frame_start_q, frame_done_q;

    logic [1:0]        pend;
    logic [1:0]        in_valid;
    logic [1:0]        take;
    setpoint_t         in_data [2];
    setpoint_t         held    [2];
    logic              take_ctrl, take_host, flush;

    movo_step_timer #(
        .BIT_DIV (BIT_DIV),
        .STEP_W  (STEP_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (timer_clear),
        .slot_o  (slot),
        .step_o  (step)
    );

    // Timer is cleared on every state change so each state counts from slot 0.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (enable) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d     = ST_IDLE;
                    timer_clear = 1'b1;
                end else if (slot && step == GAP_LAST) begin
                    state_d     = ST_FRAME;
                    timer_clear = 1'b1;
                    commit      = 1'b1;
                end
            end
            ST_FRAME: begin
                if (slot && step == FRAME_LAST) begin
                    state_d     = enable ? ST_GAP : ST_IDLE;
                    timer_clear = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                timer_clear = 1'b1;
            end
        endcase
    end

    assign in_valid[IDX_CTRL] = ctrl_valid;
    assign in_valid[IDX_HOST] = host_valid;
    assign in_data[IDX_CTRL]  = {ctrl_a, ctrl_b};
    assign in_data[IDX_HOST]  = {host_a, host_b};
    assign take[IDX_CTRL]     = take_ctrl | flush;
    assign take[IDX_HOST]     = take_host | flush;

    // One-deep pending slot per source; an accept needs the slot empty, so it
    // can never collide with the consume of the same slot.
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
        logic      pend_q;
        setpoint_t buf_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pend_q <= 1'b0;
                buf_q  <= '0;
            end else if (in_valid[gi] && !pend_q) begin
                pend_q <= 1'b1;
                buf_q  <= in_data[gi];
            end else if (take[gi]) begin
                pend_q <= 1'b0;
            end
        end

        assign pend[gi] = pend_q;
        assign held[gi] = buf_q;
    end

    assign ctrl_ready = ~pend[IDX_CTRL];
    assign host_ready = ~pend[IDX_HOST];

    always_comb begin
        val_d     = val_q;
        src_d     = src_q;
        stale_d   = stale_q;
        wdog_d    = wdog_q;
        take_ctrl = 1'b0;
        take_host = 1'b0;
        flush     = 1'b0;
        if (commit) begin
            if (fault) begin
                val_d = '0;
                src_d = SRC_FAULT;
                flush = 1'b1;
            end else if (host_mode && pend[IDX_HOST]) begin
                val_d     = held[IDX_HOST];
                src_d     = SRC_HOST;
                take_host = 1'b1;
            end else if (!host_mode && pend[IDX_CTRL]) begin
                val_d     = held[IDX_CTRL];
                src_d     = SRC_CTRL;
                take_ctrl = 1'b1;
                wdog_d    = '0;
                stale_d   = 1'b0;
            end else if (!host_mode && WDOG_FRAMES != 0) begin
                // Starved controller frame: count toward the watchdog, saturating.
                if (wdog_q != WD_LIMIT) wdog_d = wdog_q + WD_W'(1);
                if (wdog_d == WD_LIMIT) begin
                    val_d   = '0;
                    stale_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            val_q         <= '0;
            src_q         <= SRC_NONE;
            stale_q       <= 1'b0;
            wdog_q        <= '0;
            ser_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            val_q         <= val_d;
            src_q         <= src_d;
            stale_q       <= stale_d;
            wdog_q        <= wdog_d;
            ser_en_q      <= (state_q == ST_FRAME) && slot;
            frame_start_q <= commit;
            frame_done_q  <= (state_q == ST_FRAME) && slot && (step == FRAME_LAST);
        end
    end

    assign ser_en      = ser_en_q;
    assign value_a     = val_q.a;
    assign value_b     = val_q.b;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign src         = src_q;
    assign stale       = stale_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/movo_scheduler.md
# movo_scheduler

Frame scheduler and source arbiter in front of the 16-bit MOVO v2 serializer for the SERVOLAND SVF drivers. It owns the serializer's step strobe and the `value_A`/`value_B` setpoint pair. It arbitrates between three setpoint sources:

- fault override (forces zero);
- host/manual;
- the closed-loop suspension controller.

Setpoints change only at frame boundaries. A watchdog zeroes the drive if the controller stops supplying data.

## Interface
Reset is asynchronous and active-low. All logic runs in the single clock domain `clk`.

Parameters:
- `BIT_DIV`, default 4: clocks per serializer step; 2 or more.
- `GAP_STEPS`, default 8: idle step slots between frames; 1 or more.
- `WDOG_FRAMES`, default 16: consecutive controller-mode frames without fresh controller data before zeroing; 0 disables.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, level.
- `fault`  in  1  level; forces zero setpoints.
- `host_mode`  in  1  level; 1 selects the host source over the controller.
- `ctrl_valid`, `ctrl_ready`  in/out  1  controller handshake.
- `ctrl_a`, `ctrl_b`  in  16 signed  controller setpoints.
- `host_valid`, `host_ready`  in/out  1  host handshake.
- `host_a`, `host_b`  in  16 signed  host setpoints.
- `ser_en`  out  1  one-cycle step strobe to the serializer.
- `value_a`, `value_b`  out  16 signed  committed setpoints to the serializer.
- `frame_start`  out  1  one-cycle pulse; commit happened this cycle.
- `frame_done`  out  1  one-cycle pulse, coincident with step 31's `ser_en`.
- `src`  out  2  source of the current commit.
- `stale`  out  1  watchdog expired.
- `busy`  out  1  state is not IDLE.

## Operation
- States and transitions:
  - IDLE: leave for GAP when `enable`=1.
  - GAP: runs `GAP_STEPS` slots of `BIT_DIV` clocks, with `ser_en` held 0. It then commits and goes to FRAME.
  - FRAME: produces exactly 32 `ser_en` pulses, one every `BIT_DIV` clocks, for steps 0..31. After step 31 it goes to GAP if `enable`=1, otherwise IDLE.
- Deasserting `enable` mid-frame or mid-gap:
  - a frame in progress always completes all 32 steps;
  - a gap in progress aborts to IDLE with no commit.
- Pending registers:
  - one-deep pending register per source;
  - `*_ready` = pending empty;
  - accept on `valid && ready`.
- Commit, on the GAP→FRAME edge, in priority order:
  1. `fault`=1: commit 0/0, `src`=FAULT, flush both pendings.
  2. `host_mode`=1 and host pending: commit host, clear host pending.
  3. `host_mode`=0 and ctrl pending: commit ctrl, clear ctrl pending, reset watchdog count, `stale`←0.
  4. Otherwise hold the last values, `src` unchanged. In controller mode the watchdog count is incremented, saturating. When it reaches `WDOG_FRAMES`, commit 0/0 and set `stale`←1.
- Mode-switch behaviour:
  - in host mode, the ctrl pending is retained but not consumed;
  - the watchdog is frozen in host mode and during fault.
- `value_a`/`value_b` change only on a commit edge. They are stable through all 32 steps, including step 31.
- Source encoding for `src`: NONE=0, CTRL=1, HOST=2, FAULT=3.

## Timing
- Reset values:
  - `value_a`=`value_b`=0;
  - `ser_en`, `frame_start`, `frame_done`, `stale`, `busy` = 0;
  - `src`=NONE;
  - `ctrl_ready`=`host_ready`=1;
  - state IDLE, counters 0, pendings empty, watchdog count 0.
- Reset asserted mid-frame forces these values immediately. There is no partial-frame completion.
- Frame period: (32+`GAP_STEPS`)·`BIT_DIV` clocks. With the defaults this is 160.
- Start-up: the first commit is `GAP_STEPS`·`BIT_DIV` clocks after `enable` is sampled 1.
- Within FRAME, `ser_en` for step k is high `BIT_DIV`·(k+1) clocks after `frame_start`.
- Handshake:
  - `*_ready` falls on the clock after an accept;
  - `*_ready` rises on the clock after the commit that consumes the pending.
- A commit and a valid on the same cycle: no accept, because `ready` is 0. The accept happens on the next cycle.
- Worst-case accept-to-output latency: one frame period plus 1 clock.
- `fault` and `host_mode` are sampled only on the commit edge.

## Structure
- Package `movo_pkg` holds:
  - `src_t` with the encodings above;
  - `state_t` (IDLE/GAP/FRAME);
  - `FRAME_STEPS`=32;
  - the `$clog2`-derived counter widths.
- Sub-module `movo_step_timer` holds the `BIT_DIV` prescaler and step counter. It outputs the slot strobe and the step index; its `clear` input is driven by the FSM.
- The top level holds the FSM, the pendings, the arbiter and the watchdog.

## Test plan
All scenarios use the default parameters.
- Reset release, then `enable`=1, ctrl pushes A=0x1234, B=-5 → `frame_start` at clock 32, `value_a`=0x1234, `value_b`=-5, `src`=1. Then 32 `ser_en` pulses spaced 4 clocks apart, with `frame_done` on the 32nd.
- Ctrl pushes every frame, `host_mode` toggled to 1 with host pending A=100 → the next commit gives `src`=2 and `value_a`=100. The ctrl pending is held and `ctrl_ready`=0 until `host_mode` returns to 0.
- `fault`=1 for one commit with both sources pending → 0/0, `src`=3, both `*_ready`=1 on the next clock.
- Ctrl goes silent after one push → the value is held for 15 commits. The 16th commit gives 0/0 and `stale`=1. The next ctrl push clears `stale` at the following commit.
- `enable` dropped at step 10 → steps 11..31 still strobe, then `busy`=0. `enable` dropped mid-gap → IDLE with no `frame_start`.
- `rst` asserted at step 20 → all outputs at their reset values in the same cycle, `ser_en` stays 0 afterwards, and `ctrl_ready`=1.
